// File: rtl/seq_shifter.sv
// ============================================================================
// Module   : seq_shifter
// Purpose  : Multi-cycle shift register with load, shift-left, shift-right and
//            rotate-right operations, and a 0-3 step count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2 (
  input  logic i_sel,
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = i_sel ? i_b : i_a;
endmodule

module seq_shifter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [1:0]       amount,
  input  logic [WIDTH-1:0] din,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             carry_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] c_OP_LOAD = 2'b00;
  localparam logic [1:0] c_OP_SHL  = 2'b01;
  localparam logic [1:0] c_OP_ROR  = 2'b11;

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_SHIFT = 2'd1;
  localparam logic [1:0] c_S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [1:0]       r_op;
  logic [1:0]       r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_carry;

  logic             w_accept;
  logic             w_load;
  logic             w_step;
  logic             w_shl;
  logic             w_ror;
  logic             w_fill;
  logic             w_carry_next;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_stepped;
  logic [WIDTH-1:0] w_q_next;

  assign w_accept = (r_state == c_S_IDLE) && start;
  assign w_load   = w_accept && (op == c_OP_LOAD);
  assign w_step   = (r_state == c_S_SHIFT);
  assign w_shl    = (r_op == c_OP_SHL);
  assign w_ror    = (r_op == c_OP_ROR);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (start) begin
          if ((op == c_OP_LOAD) || (amount == 2'd0)) begin
            w_next_state = c_S_DONE;
          end else begin
            w_next_state = c_S_SHIFT;
          end
        end
      end
      c_S_SHIFT: begin
        if (r_cnt == 2'd1) begin
          w_next_state = c_S_DONE;
        end
      end
      c_S_DONE: begin
        w_next_state = c_S_IDLE;
      end
      default: begin
        w_next_state = c_S_IDLE;
      end
    endcase
  end

  // Output decode from registered state
  always_comb begin
    busy = (r_state != c_S_IDLE);
    done = (r_state == c_S_DONE);
  end

  // The step counter doubles as the latched copy of amount
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op  <= c_OP_LOAD;
      r_cnt <= 2'd0;
    end else if (w_accept) begin
      r_op  <= op;
      r_cnt <= amount;
    end else if (w_step) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  // MSB fill: serial_in for SHR, old LSB for ROR
  mux2 u_fill (
    .i_sel (w_ror),
    .i_a   (serial_in),
    .i_b   (r_q[0]),
    .o_y   (w_fill)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_left;
    logic w_right;

    if (i == 0) begin : g_lsb
      assign w_left = serial_in;
    end else begin : g_nlsb
      assign w_left = r_q[i-1];
    end

    if (i == WIDTH - 1) begin : g_msb
      assign w_right = w_fill;
    end else begin : g_nmsb
      assign w_right = r_q[i+1];
    end

    mux2 u_dir (
      .i_sel (w_shl),
      .i_a   (w_right),
      .i_b   (w_left),
      .o_y   (w_shifted[i])
    );

    mux2 u_step (
      .i_sel (w_step),
      .i_a   (r_q[i]),
      .i_b   (w_shifted[i]),
      .o_y   (w_stepped[i])
    );

    mux2 u_load (
      .i_sel (w_load),
      .i_a   (w_stepped[i]),
      .i_b   (din[i]),
      .o_y   (w_q_next[i])
    );
  end

  always_comb begin
    w_carry_next = r_carry;
    if (w_load) begin
      w_carry_next = 1'b0;
    end else if (w_step) begin
      w_carry_next = w_shl ? r_q[WIDTH-1] : r_q[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= '0;
      r_carry <= 1'b0;
    end else begin
      r_q     <= w_q_next;
      r_carry <= w_carry_next;
    end
  end

  assign q         = r_q;
  assign carry_out = r_carry;

endmodule

`default_nettype wire
